// File: rtl/ddr_deser_pkg.sv
// Shared constants and elaboration helpers for the DDR pair deserializer.
package ddr_deser_pkg;

    // Bit order within a captured pair: the rising-edge bit arrived first.
    localparam int unsigned DDR_H = 0;
    localparam int unsigned DDR_L = 1;

    function automatic bit w_ok(int unsigned w);
        return (w % 2 == 0) && (w >= 4);
    endfunction

endpackage

// File: rtl/ddr_deser_if.sv
// Pair input and valid/ready word output bundle of the DDR deserializer.
interface ddr_deser_if #(
    parameter int unsigned W = 24
);
    logic         en_i;
    logic [1:0]   ddr_i;
    logic         sync_i;
    logic [W-1:0] data_o;
    logic         valid_o;
    logic         ready_i;
    logic         locked_o;
    logic         sync_err_o;
    logic         ovf_o;

    modport master (
        output en_i, ddr_i, sync_i, ready_i,
        input  data_o, valid_o, locked_o, sync_err_o, ovf_o
    );

    modport slave (
        input  en_i, ddr_i, sync_i, ready_i,
        output data_o, valid_o, locked_o, sync_err_o, ovf_o
    );
endinterface

// File: rtl/ddr_deser_oreg.sv
// Single-entry valid/ready output register; a word arriving while full and
// not being drained is dropped and flagged with a one-cycle overrun pulse.
module ddr_deser_oreg #(
    parameter int unsigned W = 24
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         ovf_o
);

    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic         ovf_q, ovf_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovf_d   = 1'b0;
        if (load_i) begin
            if (!valid_q || ready_i) begin
                data_d  = data_i;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/ddr_deser.sv
// Assembles DDR bit pairs MSB-first into W-bit words aligned by a frame strobe,
// freewheeling between strobes and flagging strobes off the word boundary.
module ddr_deser
    import ddr_deser_pkg::*;
#(
    parameter int unsigned W = 24
) (
    input logic         clk_i,
    input logic         rst_n_i,
    ddr_deser_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(W / 2);
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(W / 2 - 1);

    if (!w_ok(W)) begin : g_bad_w
        $error("ddr_deser: W must be even and >= 4");
    end

    logic             locked_q, locked_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Only the W-2 older bits are stored; the current pair completes the word.
    logic [W-3:0]     shift_q, shift_d;
    logic             sync_err_q, sync_err_d;
    logic [1:0]       pair;
    logic [W-1:0]     word;
    logic             complete;

    assign pair = {bus.ddr_i[DDR_H], bus.ddr_i[DDR_L]};
    assign word = {shift_q, pair};

    always_comb begin
        locked_d   = locked_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        sync_err_d = 1'b0;
        complete   = 1'b0;
        if (bus.en_i) begin
            // Older bits fall off the top before completion, so a fresh word
            // can always shift in without clearing first.
            shift_d = word[W-3:0];
            if (!locked_q) begin
                if (bus.sync_i) begin
                    locked_d = 1'b1;
                    cnt_d    = CNT_W'(1);
                end
            end else if (bus.sync_i && cnt_q != '0) begin
                sync_err_d = 1'b1;
                cnt_d      = CNT_W'(1);
            end else if (cnt_q == LastCnt) begin
                complete = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            locked_q   <= 1'b0;
            cnt_q      <= '0;
            shift_q    <= '0;
            sync_err_q <= 1'b0;
        end else begin
            locked_q   <= locked_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            sync_err_q <= sync_err_d;
        end
    end

    ddr_deser_oreg #(
        .W (W)
    ) u_oreg (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (complete),
        .data_i  (word),
        .ready_i (bus.ready_i),
        .data_o  (bus.data_o),
        .valid_o (bus.valid_o),
        .ovf_o   (bus.ovf_o)
    );

    assign bus.locked_o   = locked_q;
    assign bus.sync_err_o = sync_err_q;

endmodule
